// File: rtl/ex_issue_ctrl.sv
// ID->EX issue control: owns the ID/EX register, picks forwarded
// operands, inserts load-use and JALR bubbles, freezes on mem_stall.
module ex_issue_ctrl #(
   parameter logic [31:0] NOP_IW   = 32'h00000013,
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_stall,
   input  logic        id_valid,
   input  logic [31:0] id_iw,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic        df_ex_enable,
   input  logic [4:0]  df_ex_reg,
   input  logic [31:0] df_ex_data,
   input  logic        df_mem_enable,
   input  logic [4:0]  df_mem_reg,
   input  logic [31:0] df_mem_data,
   input  logic        df_wb_enable,
   input  logic [4:0]  df_wb_reg,
   input  logic [31:0] df_wb_data,
   output logic        id_stall,
   output logic        ex_valid,
   output logic [31:0] ex_iw,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_data,
   output logic [31:0] ex_rs2_data,
   output logic        jalr_redirect,
   output logic [31:0] jalr_target
);

   typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   state_t      state_q;
   logic        ex_valid_q;
   logic [31:0] ex_iw_q;
   logic [31:0] ex_pc_q;
   logic [31:0] ex_rs1_q;
   logic [31:0] ex_rs2_q;

   logic [6:0]  id_op;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  ex_rd;
   logic        use_rs1;
   logic        use_rs2;
   logic        load_use;
   logic        jalr_in_ex;
   logic [31:0] rs1_d;
   logic [31:0] rs2_d;

   // Priority forward: EX, then MEM, then WB, else register file; x0 is 0.
   function automatic logic [31:0] fwd(input logic [4:0]  rs,
                                       input logic [31:0] rf);
      logic [31:0] v;
      v = rf;
      if (rs == 5'd0)
         v = 32'd0;
      else if (df_ex_enable && df_ex_reg == rs)
         v = df_ex_data;
      else if (df_mem_enable && df_mem_reg == rs)
         v = df_mem_data;
      else if (df_wb_enable && df_wb_reg == rs)
         v = df_wb_data;
      return v;
   endfunction

   // Decode source usage and hazards from the ID word and the EX register.
   always_comb begin
      id_op   = id_iw[6:0];
      id_rs1  = id_iw[19:15];
      id_rs2  = id_iw[24:20];
      ex_rd   = ex_iw_q[11:7];
      use_rs2 = (id_op == OP_R) || (id_op == OP_ST) || (id_op == OP_BR);
      use_rs1 = use_rs2 || (id_op == OP_IMM) || (id_op == OP_LD)
                || (id_op == OP_JALR);
      load_use = id_valid && ex_valid_q && (ex_iw_q[6:0] == OP_LD)
                 && (ex_rd != 5'd0)
                 && ((use_rs1 && id_rs1 == ex_rd)
                     || (use_rs2 && id_rs2 == ex_rd));
      jalr_in_ex = ex_valid_q && (ex_iw_q[6:0] == OP_JALR);
      rs1_d = fwd(id_rs1, id_rs1_data);
      rs2_d = fwd(id_rs2, id_rs2_data);
   end

   // Stall/redirect strobes come from state and EX contents only, not outputs.
   always_comb begin
      id_stall      = mem_stall
                      || (state_q == RUN && !jalr_in_ex && load_use);
      jalr_redirect = !mem_stall && state_q == RUN && jalr_in_ex;
      jalr_target   = (ex_rs1_q + {{20{ex_iw_q[31]}}, ex_iw_q[31:20]})
                      & ~32'h1;
   end

   // FSM and ID/EX register; mem_stall freezes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         ex_valid_q <= 1'b0;
         ex_iw_q    <= NOP_IW;
         ex_pc_q    <= RESET_PC;
         ex_rs1_q   <= 32'd0;
         ex_rs2_q   <= 32'd0;
      end else if (!mem_stall) begin
         unique case (state_q)
            RUN: begin
               if (jalr_in_ex || load_use) begin
                  ex_valid_q <= 1'b0;
                  ex_iw_q    <= NOP_IW;
                  ex_rs1_q   <= 32'd0;
                  ex_rs2_q   <= 32'd0;
                  state_q    <= jalr_in_ex ? FLUSH : LOAD_STALL;
               end else begin
                  ex_valid_q <= id_valid;
                  ex_iw_q    <= id_iw;
                  ex_pc_q    <= id_pc;
                  ex_rs1_q   <= rs1_d;
                  ex_rs2_q   <= rs2_d;
               end
            end
            LOAD_STALL: begin
               ex_valid_q <= id_valid;
               ex_iw_q    <= id_iw;
               ex_pc_q    <= id_pc;
               ex_rs1_q   <= rs1_d;
               ex_rs2_q   <= rs2_d;
               state_q    <= RUN;
            end
            FLUSH: begin
               ex_valid_q <= 1'b0;
               ex_iw_q    <= NOP_IW;
               ex_rs1_q   <= 32'd0;
               ex_rs2_q   <= 32'd0;
               state_q    <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_iw       = ex_iw_q;
   assign ex_pc       = ex_pc_q;
   assign ex_rs1_data = ex_rs1_q;
   assign ex_rs2_data = ex_rs2_q;

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
- Controls issue of instructions from decode into the execute stage (ALU) of the 32-bit RISC-V pipeline.
- Owns the ID->EX pipeline register.
- Selects forwarded operands with priority EX > MEM > WB > register file.
- Detects load-use hazards and inserts one bubble for each.
- Squashes wrong-path instructions after a JALR and redirects fetch.
- Freezes on a memory-side stall.

Parameters:
NOP_IW, 32'h00000013, instruction word inserted as a bubble (addi x0,x0,0)
RESET_PC, 32'h00000000, ex_pc value after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
mem_stall  in  1  memory stage busy; freezes this block
id_valid  in  1  decode holds a valid instruction
id_iw  in  32  decoded instruction word
id_pc  in  32  PC of decode instruction
id_rs1_data  in  32  register-file rs1 value
id_rs2_data  in  32  register-file rs2 value
df_ex_enable  in  1  EX-stage result writes back
df_ex_reg  in  5  EX-stage destination
df_ex_data  in  32  EX-stage ALU result
df_mem_enable  in  1  MEM-stage result writes back
df_mem_reg  in  5  MEM-stage destination
df_mem_data  in  32  MEM-stage result (load data for loads)
df_wb_enable  in  1  WB-stage write enable
df_wb_reg  in  5  WB destination
df_wb_data  in  32  WB data
id_stall  out  1  decode/fetch hold their instruction this cycle
ex_valid  out  1  EX register holds a real instruction
ex_iw  out  32  instruction word presented to the ALU
ex_pc  out  32  PC presented to the ALU
ex_rs1_data  out  32  forwarded rs1 operand
ex_rs2_data  out  32  forwarded rs2 operand
jalr_redirect  out  1  one-cycle pulse: fetch restarts at jalr_target
jalr_target  out  32  (ex_rs1_data + sext(ex_iw[31:20])) & ~32'h1

Behaviour:
- Reset: state=RUN, ex_valid=0, ex_iw=NOP_IW, ex_pc=RESET_PC, ex_rs1_data=ex_rs2_data=0, id_stall=0, jalr_redirect=0. Reset overrides mem_stall and any stall or flush in progress.
- Source usage by opcode:
  - 0110011, 0100011, 1100011: read rs1 and rs2.
  - 0010011, 0000011, 1100111: read rs1 only.
  - All other opcodes: read no sources.
  - Register x0 never causes a hazard and is never forwarded; its value is always 0.
- Forwarding (combinational, sampled at the capture edge), per operand: first match of EX, then MEM, then WB, requiring enable=1 and reg==rs!=0; otherwise the register-file value.
- load_use = id_valid AND the EX register holds a load (ex_valid, opcode 0000011) AND its rd (ex_iw[11:7]) != 0 AND rd equals a used rs of id_iw.
- jalr_in_ex = ex_valid AND ex_iw opcode 1100111.
- FSM states: RUN, LOAD_STALL, FLUSH.
  - RUN:
    - If mem_stall: hold everything, id_stall=1.
    - Else if jalr_in_ex: jalr_redirect=1; capture bubble; go to FLUSH.
    - Else if load_use: id_stall=1; capture bubble; go to LOAD_STALL.
    - Else: capture id_* with forwarding; ex_valid<=id_valid.
  - LOAD_STALL: lasts one cycle, id_stall=0. Capture the held ID instruction (load data now arrives via df_mem), then go to RUN. If mem_stall: hold.
  - FLUSH: the wrong-path instruction in ID is discarded; capture bubble; go to RUN. If mem_stall: hold in FLUSH.
- Bubble: ex_valid=0, ex_iw=NOP_IW, ex_pc unchanged, operands=0.
- JALR penalty is 2 bubbles; load-use penalty is 1 bubble.
- mem_stall freezes all registers and the FSM. jalr_redirect=0 while frozen; a pending redirect fires in the first unstalled cycle.
- jalr_redirect is at most one pulse per JALR.
- id_stall depends combinationally on the current ID/EX contents and must not depend on any ex_* output of the same cycle through a loop.
- jalr_target bit 0 is always 0. Addition wraps modulo 2^32.

Test Plan:
- Back-to-back forwarding:
  - Stimulus: addi x5,x0,7, then add x6,x5,x5, with df_ex_reg=5, df_ex_data=7 and the register file returning 0.
  - Required: ex_rs1_data=ex_rs2_data=7 and no stall.
- Forwarding priority:
  - Stimulus: EX, MEM and WB all target x3 with data 1, 2 and 3; ID reads x3.
  - Required: operand=1. With EX disabled: 2. Targeting x0 with data 9: operand=0.
- Load-use:
  - Stimulus: lw x4,0(x1) in EX; ID holds add x7,x4,x2.
  - Required: id_stall=1 for exactly one cycle; one bubble with ex_iw=32'h00000013, ex_valid=0. Next cycle the add issues with rs1=df_mem_data (e.g. 32'hDEADBEEF).
  - Repeat with rd=x0: required no stall.
- JALR:
  - Stimulus: jalr x1,12(x2) in EX with x2=32'h1001.
  - Required: jalr_redirect pulses one cycle with jalr_target=32'h100C; the next two ID instructions become bubbles; then normal issue resumes.
- mem_stall:
  - Stimulus: assert mem_stall for 3 cycles during RUN, LOAD_STALL and FLUSH (with a JALR in EX).
  - Required: all outputs and state are held and no redirect is issued while stalled. The redirect pulse appears in the first cycle after mem_stall falls.
- Reset mid-operation:
  - Stimulus: assert reset in LOAD_STALL and in FLUSH.
  - Required: next cycle ex_valid=0, ex_iw=NOP_IW, ex_pc=RESET_PC, id_stall=0, state RUN.
